// File: rtl/ifid_skid_reg_if.sv
// IF/ID boundary bundle: fetch-side valid/ready/data, decode-side valid/ready/data and the redirect flush.
// master = surrounding pipeline (IF, ID, hazard unit), slave = the skid register.
interface ifid_skid_reg_if #(parameter int XLEN = 32);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } ifid_t;

  logic  flush;
  logic  in_valid;
  logic  in_ready;
  ifid_t in_data;
  logic  out_valid;
  logic  out_ready;
  ifid_t out_data;

  modport master (output flush, in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  flush, in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer; in_ready is decoded from state only.
// Optional IFID_PERF_EN adds a saturating bubble_cnt of cycles with out_valid low.
module ifid_skid_reg #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               reset,
`ifdef IFID_PERF_EN
  output logic [31:0]        bubble_cnt,
`endif
  ifid_skid_reg_if.slave     bus
);
  localparam int W = 3 * XLEN;

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   main_q, skid_q;
  logic           in_fire, out_fire;
  logic           load_main_in, load_main_skid, load_skid;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (in_fire) state_nxt = FULL;
        FULL: begin
          if (in_fire && !out_fire)      state_nxt = SKID;
          else if (!in_fire && out_fire) state_nxt = EMPTY;
        end
        SKID:    if (out_fire) state_nxt = FULL;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    bus.in_ready   = (state != SKID);
    bus.out_valid  = (state != EMPTY);
    bus.out_data   = main_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (!bus.flush) begin
      case (state)
        EMPTY:   load_main_in = in_fire;
        FULL: begin
          load_main_in = in_fire & out_fire;
          load_skid    = in_fire & ~out_fire;
        end
        SKID:    load_main_skid = out_fire;
        default: ;
      endcase
    end
  end

  // Flush only clears state; data registers may hold stale bundles.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= bus.in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= bus.in_data;
    end
  end

`ifdef IFID_PERF_EN
  always_ff @(posedge clk) begin
    if (reset)                                bubble_cnt <= '0;
    else if (!bus.out_valid && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_ifid_skid_reg.sv
// Directed and randomized checks of ifid_skid_reg: handshake, skid, flush, reset and ordering.
module tb_ifid_skid_reg;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ifid_skid_reg_if #(.XLEN(32)) bus();

`ifdef IFID_PERF_EN
  logic [31:0] bubble_cnt;
  ifid_skid_reg #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bubble_cnt(bubble_cnt), .bus(bus));
`else
  ifid_skid_reg #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    bus.in_valid          = v;
    bus.in_data.pc        = pc;
    bus.in_data.pc_plus4  = pc + 32'd4;
    bus.in_data.instr     = pc ^ 32'h00500093;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.flush = 1'b0; bus.out_ready = 1'b0; drive(1'b0, 32'h0);
    step(); step();
    reset = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_data !== 96'h0) begin miscompares++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_stream();
    logic [31:0] pcs [3];
    pcs[0] = 32'h00; pcs[1] = 32'h04; pcs[2] = 32'h08;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pcs[i]);
      step();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data.pc !== pcs[i] || bus.out_data.pc_plus4 !== pcs[i] + 32'd4) begin
        miscompares++; $display("FAIL stream_%0d got v=%b pc=%h want v=1 pc=%h", i, bus.out_valid, bus.out_data.pc, pcs[i]);
      end
    end
    drive(1'b0, 32'h0);
    step();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain got v=%b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h10); step();
    vectors++; if (bus.in_ready !== 1'b1 || bus.out_data.pc !== 32'h10) begin miscompares++; $display("FAIL bp_full got rdy=%b pc=%h want rdy=1 pc=10", bus.in_ready, bus.out_data.pc); end
    drive(1'b1, 32'h14); step();
    vectors++; if (bus.in_ready !== 1'b0 || bus.out_data.pc !== 32'h10) begin miscompares++; $display("FAIL bp_skid got rdy=%b pc=%h want rdy=0 pc=10", bus.in_ready, bus.out_data.pc); end
    drive(1'b1, 32'h18); step();
    vectors++; if (bus.in_ready !== 1'b0 || bus.out_data.pc !== 32'h10) begin miscompares++; $display("FAIL bp_hold got rdy=%b pc=%h want rdy=0 pc=10", bus.in_ready, bus.out_data.pc); end
    bus.out_ready = 1'b1; step();
    vectors++; if (bus.in_ready !== 1'b1 || bus.out_data.pc !== 32'h14) begin miscompares++; $display("FAIL bp_rel1 got rdy=%b pc=%h want rdy=1 pc=14", bus.in_ready, bus.out_data.pc); end
    step();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_data.pc !== 32'h18) begin miscompares++; $display("FAIL bp_rel2 got v=%b pc=%h want v=1 pc=18", bus.out_valid, bus.out_data.pc); end
    drive(1'b0, 32'h0); step();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got v=%b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h30); step();
    drive(1'b1, 32'h34); step();
    bus.flush = 1'b1; drive(1'b1, 32'h40); step();
    bus.flush = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_skid got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready); end
    // Flush from FULL while in_ready is high: the accepted 0x54 must be discarded.
    drive(1'b1, 32'h50); step();
    bus.flush = 1'b1; drive(1'b1, 32'h54); step();
    bus.flush = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_full got v=%b pc=%h want v=0", bus.out_valid, bus.out_data.pc); end
    bus.out_ready = 1'b1; drive(1'b1, 32'h80); step();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_data.pc !== 32'h80) begin miscompares++; $display("FAIL flush_after got v=%b pc=%h want v=1 pc=80", bus.out_valid, bus.out_data.pc); end
    drive(1'b0, 32'h0); step();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_drain got v=%b want 0", bus.out_valid); end
  endtask

  task automatic test_hold();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data.pc = 32'h20; bus.in_data.pc_plus4 = 32'h24; bus.in_data.instr = 32'h00500093;
    step();
    drive(1'b1, 32'h99);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data.pc !== 32'h20 || bus.out_data.instr !== 32'h00500093) begin
        miscompares++; $display("FAIL hold_%0d got v=%b pc=%h instr=%h want pc=20 instr=00500093", i, bus.out_valid, bus.out_data.pc, bus.out_data.instr);
      end
      if (i == 0) drive(1'b0, 32'h0);
      step();
    end
    bus.out_ready = 1'b1; step(); step();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL hold_drain got v=%b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_skid();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h60); step();
    drive(1'b1, 32'h64); step();
    reset = 1'b1; step();
    reset = 1'b0; drive(1'b0, 32'h0);
    vectors++; if (bus.out_valid !== 1'b0 || bus.out_data !== 96'h0 || bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_skid got v=%b data=%h rdy=%b want 0/0/1", bus.out_valid, bus.out_data, bus.in_ready);
    end
`ifdef IFID_PERF_EN
    vectors++; if (bubble_cnt !== 32'd0) begin miscompares++; $display("FAIL bubble_reset got %0d want 0", bubble_cnt); end
    step(); step(); step();
    vectors++; if (bubble_cnt !== 32'd3) begin miscompares++; $display("FAIL bubble_idle got %0d want 3", bubble_cnt); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] next_pc = 32'h1000;
    logic [31:0] exp;
    logic        rdy_before;
    int          received = 0;
    int          cycles = 0;
    bus.flush = 1'b0;
    while (received < 10000 && cycles < 40000) begin
      rdy_before = bus.in_ready;
      drive(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, next_pc);
      bus.out_ready = ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0;
      #1;
      if (bus.in_ready !== rdy_before) begin
        vectors++; miscompares++; $display("FAIL rand_ready_comb in_ready moved %b->%b mid-cycle", rdy_before, bus.in_ready);
      end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++; $display("FAIL rand_order got pc=%h want nothing pending", bus.out_data.pc);
        end else begin
          exp = q.pop_front();
          if (bus.out_data.pc !== exp || bus.out_data.pc_plus4 !== exp + 32'd4 || bus.out_data.instr !== (exp ^ 32'h00500093)) begin
            miscompares++; $display("FAIL rand_order got pc=%h want pc=%h", bus.out_data.pc, exp);
          end
        end
        received++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(next_pc);
        next_pc += 32'd4;
      end
      step();
      cycles++;
    end
    vectors++;
    if (received < 10000) begin miscompares++; $display("FAIL rand_timeout got %0d bundles want 10000", received); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_hold();
    test_reset_skid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ifid_skid_reg.md
Name: ifid_skid_reg

Overview:
- IF/ID pipeline boundary register. It captures the fetch stage's ifid_t bundle (PC, PCPlus4, instr) and presents it to the decode stage one cycle later.
- Uses a valid/ready handshake on both sides with a 2-entry skid buffer. The upstream ready therefore never depends combinationally on the downstream ready.
- Synchronous flush for branch/jump redirects, driven by the hazard unit.

Parameters:
- XLEN, 32, datapath width. The ifid_t payload is 3*XLEN bits (PC, PCPlus4, instr).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous kill of all buffered entries (redirect).
- in_valid  input  1  IF stage presents a valid bundle.
- in_ready  output  1  block accepts a bundle this cycle.
- in_data  input  ifid_t  bundle from IF stage (PC, PCPlus4, instr).
- out_valid  output  1  bundle presented to ID stage.
- out_ready  input  1  ID stage accepts the bundle this cycle.
- out_data  output  ifid_t  bundle to ID stage.

Behaviour:
- Clocking: one clock, clk; reset is synchronous and active-high.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Transfers occur only on fire.
  - in_data and out_data are don't-care when the matching valid is low.
- Storage: main register (drives out_data/out_valid) and skid register.
- States:
  - EMPTY: main invalid.
  - FULL: main valid, skid invalid.
  - SKID: both valid.
- in_ready = (state != SKID). It is decoded from the state register only; there is no combinational path from out_ready.
- out_valid = (state != EMPTY). out_data = main register.
- Transitions (when not reset and not flush):
  - EMPTY + in_fire -> FULL, main <= in_data.
  - EMPTY + no in_fire -> EMPTY.
  - FULL + in_fire + out_fire -> FULL, main <= in_data.
  - FULL + in_fire + !out_fire -> SKID, skid <= in_data.
  - FULL + !in_fire + out_fire -> EMPTY.
  - FULL + neither -> FULL, hold.
  - SKID + out_fire -> FULL, main <= skid. No upstream accept is possible in SKID.
  - SKID + !out_fire -> SKID, hold.
- Latency: a bundle accepted in cycle N appears on out_data in cycle N+1 if main was empty or drained in N.
- Throughput: one bundle per cycle while out_ready stays high.
- Ordering: strict FIFO. No bundle is dropped or duplicated, except by flush or reset.
- Flush:
  - Next state is EMPTY and both entries are invalidated.
  - A bundle fired on in_* in the same cycle as flush is discarded.
  - An out_fire in the flush cycle still counts as consumed by ID.
  - The data registers may keep stale contents.
- Reset:
  - Priority over flush. State becomes EMPTY and main/skid data are cleared to 0.
  - Output values after the reset edge: out_valid = 0, out_data = 0, in_ready = 1.
  - Any in-flight bundle is lost when reset is asserted mid-operation.
- Stability: while out_valid = 1 and out_ready = 0, out_data must not change.

Optional Feature:
- Macro: IFID_PERF_EN.
- Defined:
  - Adds output port bubble_cnt, 32 bits: count of cycles with out_valid = 0.
  - Increments by 1 each non-reset cycle in which out_valid = 0.
  - Saturates at 0xFFFFFFFF.
  - Cleared to 0 by reset; unaffected by flush.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then stream PC=0x00,0x04,0x08 with out_ready=1 -> out_data.PC = 0x00,0x04,0x08 on consecutive cycles, each 1 cycle after accept; out_valid continuous.
- Hold out_ready=0 and offer PC=0x10,0x14,0x18 -> 0x10 in main, 0x14 in skid, in_ready=0 the cycle after 0x14 accepted, 0x18 held upstream. Release out_ready -> 0x10,0x14,0x18 delivered in order with no loss.
- State SKID, assert flush with in_valid=1 PC=0x40 -> next cycle out_valid=0, in_ready=1; 0x40 never appears at output. Offer PC=0x80 -> output 0x80 next cycle.
- out_ready=0 for 5 cycles holding PC=0x20, instr=0x00500093 -> out_data constant for all 5 cycles.
- Assert reset in state SKID -> next cycle out_valid=0, out_data=0, in_ready=1. With IFID_PERF_EN: bubble_cnt=0, then it increments each idle cycle (3 idle cycles -> 3).
- Random valid/ready toggling, 10k bundles with incrementing PC -> scoreboard: output sequence equals accepted sequence; in_ready never falls in the same cycle as an out_ready change.
